// File: rtl/bcd2bin_defs.sv
// rtl/bcd2bin_defs.sv - shared constants for the sequential BCD-to-binary converter
package bcd2bin_defs;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_FINISH  = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] CORR_TH = 4'd8;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/sub3_ge8.sv
// rtl/sub3_ge8.sv - reverse double-dabble digit correction: subtract 3 when digit >= 8
import bcd2bin_defs::*;

module sub3_ge8 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= CORR_TH) dout = din - 4'd3;
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter, start/done handshake
import bcd2bin_defs::*;

module bcd2bin_seq #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

    localparam int BCD_W = 4 * N_DIGITS;

    if ((64'd1 << BIN_W) <= (pow10(N_DIGITS) - 64'd1)) begin : g_bin_w_check
        $error("bcd2bin_seq: BIN_W too narrow for N_DIGITS");
    end
    if ((64'd1 << CNT_W) <= 64'(BIN_W)) begin : g_cnt_w_check
        $error("bcd2bin_seq: CNT_W too narrow for BIN_W");
    end

    logic [1:0]             state, state_nx;
    logic [BCD_W-1:0]       bcd_r;
    logic [BIN_W-1:0]       bin_r;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_last;
    logic [N_DIGITS-1:0]    digit_bad;
    logic                   any_bad;
    logic [BCD_W+BIN_W-1:0] sh_all;
    logic [BCD_W-1:0]       bcd_sh;
    logic [BCD_W-1:0]       bcd_corr;
    logic [BIN_W-1:0]       bin_sh;

    // One reverse-dabble step: the BCD LSB walks into the binary MSB
    assign sh_all           = {bcd_r, bin_r} >> 1;
    assign {bcd_sh, bin_sh} = sh_all;
    assign cnt_last         = (cnt == CNT_W'(BIN_W - 1));
    assign any_bad          = |digit_bad;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        sub3_ge8 u_sub3 (
            .din  (bcd_sh[4*i +: 4]),
            .dout (bcd_corr[4*i +: 4])
        );
    end

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_check
        assign digit_bad[i] = (bcd_in[4*i +: 4] > BCD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = any_bad ? S_FINISH : S_CONVERT;
            S_CONVERT: if (cnt_last) state_nx = S_FINISH;
            S_FINISH:  state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        done = (state == S_FINISH);
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bcd_r <= bcd_in;
                        bin_r <= '0;
                        cnt   <= '0;
                        err   <= any_bad;
                        if (any_bad) bin_out <= '0;
                    end
                end
                S_CONVERT: begin
                    bcd_r <= bcd_corr;
                    bin_r <= bin_sh;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt_last) bin_out <= bin_sh;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed self-checking bench for bcd2bin_seq
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        done;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          lat;
    int          bcnt;
    logic [13:0] r_bin;
    logic        r_err;
    logic        p_done;
    logic        p_busy;
    logic        p_err;
    logic [15:0] r_left;

    always #5 clk = ~clk;

    bcd2bin_seq #(.N_DIGITS(4), .BIN_W(14), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .done    (done),
        .err     (err),
        .busy    (busy)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Stimulus only: launch one request and report what was observed
    task automatic convert(input logic [15:0] bcd);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = '0;
        lat    = 1;
        bcnt   = int'(busy);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            bcnt += int'(busy);
        end
        r_bin  = bin_out;
        r_err  = err;
        r_left = dut.bcd_r;
        @(negedge clk);
        p_done = done;
        p_busy = busy;
        p_err  = err;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/err=%b expected 000", {busy, done, err});
        end
        checks++;
        if (bin_out !== 14'd0) begin
            errors++;
            $display("FAIL reset_bin: got %0d expected 0", bin_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero;
        convert(16'h0000);
        checks++;
        if (lat !== 15) begin errors++; $display("FAIL zero_latency: got %0d expected 15", lat); end
        checks++;
        if (bcnt !== 15) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 15", bcnt); end
        checks++;
        if (r_bin !== 14'd0 || r_err !== 1'b0) begin
            errors++; $display("FAIL zero_result: got bin=%0d err=%b expected 0 0", r_bin, r_err);
        end
        checks++;
        if (p_done !== 1'b0 || p_busy !== 1'b0) begin
            errors++; $display("FAIL zero_after: got done=%b busy=%b expected 0 0", p_done, p_busy);
        end
    endtask

    task automatic test_values;
        logic [15:0] vin  [2] = '{16'h9999, 16'h1023};
        logic [13:0] vexp [2] = '{14'h270F, 14'h03FF};
        for (int i = 0; i < 2; i++) begin
            convert(vin[i]);
            checks++;
            if (r_bin !== vexp[i] || r_err !== 1'b0) begin
                errors++; $display("FAIL value_%h: got bin=%h err=%b expected %h 0", vin[i], r_bin, r_err, vexp[i]);
            end
            checks++;
            if (lat !== 15 || p_done !== 1'b0) begin
                errors++; $display("FAIL value_%h_timing: got lat=%0d done_next=%b expected 15 0", vin[i], lat, p_done);
            end
            checks++;
            if (r_left !== 16'h0) begin
                errors++; $display("FAIL value_%h_bcd_residue: got %h expected 0", vin[i], r_left);
            end
        end
    endtask

    task automatic test_invalid;
        convert(16'h12A4);
        checks++;
        if (lat !== 1 || bcnt !== 1) begin
            errors++; $display("FAIL invalid_latency: got lat=%0d busy=%0d expected 1 1", lat, bcnt);
        end
        checks++;
        if (r_err !== 1'b1 || r_bin !== 14'd0) begin
            errors++; $display("FAIL invalid_result: got err=%b bin=%0d expected 1 0", r_err, r_bin);
        end
        checks++;
        if (p_err !== 1'b1 || p_done !== 1'b0) begin
            errors++; $display("FAIL invalid_hold: got err=%b done=%b expected 1 0", p_err, p_done);
        end
        convert(16'h0042);
        checks++;
        if (r_err !== 1'b0 || r_bin !== 14'd42 || lat !== 15) begin
            errors++; $display("FAIL after_invalid: got err=%b bin=%0d lat=%0d expected 0 42 15", r_err, r_bin, lat);
        end
    endtask

    task automatic test_start_held;
        int t;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0500;
        repeat (5) @(negedge clk);
        bcd_in = 16'h0007;
        t = 0;
        while (!done && t < 40) begin @(negedge clk); t++; end
        checks++;
        if (done !== 1'b1 || bin_out !== 14'd500) begin
            errors++; $display("FAIL held_first: got done=%b bin=%0d expected 1 500", done, bin_out);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL held_gap: got done=%b busy=%b expected 0 0", done, busy);
        end
        t = 1;
        while (!done && t < 40) begin @(negedge clk); t++; end
        checks++;
        if (t !== 16 || bin_out !== 14'd7) begin
            errors++; $display("FAIL held_second: got spacing=%0d bin=%0d expected 16 7", t, bin_out);
        end
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dcount;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h4321;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got busy=%b done=%b bin=%0d err=%b expected 0 0 0 0", busy, done, bin_out, err);
        end
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checks++;
        if (dcount !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", dcount); end
        convert(16'h4321);
        checks++;
        if (r_bin !== 14'd4321 || lat !== 15) begin
            errors++; $display("FAIL mid_reset_retry: got bin=%0d lat=%0d expected 4321 15", r_bin, lat);
        end
    endtask

    task automatic test_sweep;
        int vals [9] = '{1, 9, 10, 99, 100, 999, 1000, 8191, 9998};
        int v;
        for (int i = 0; i < 160; i++) begin
            v = (i < 9) ? vals[i] : int'($urandom_range(0, 9999));
            convert(to_bcd(v));
            checks++;
            if (r_bin !== 14'(v) || r_err !== 1'b0 || lat !== 15) begin
                errors++; $display("FAIL sweep_%0d: got bin=%0d err=%b lat=%0d expected %0d 0 15", v, r_bin, r_err, lat, v);
            end
            checks++;
            if (r_left !== 16'h0) begin
                errors++; $display("FAIL sweep_%0d_bcd_residue: got %h expected 0", v, r_left);
            end
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_values;
        test_invalid;
        test_start_held;
        test_reset_mid;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
